// File: rtl/packet_buffer_multislot_if.sv
// packet_buffer_multislot_if: receive-side and send-side handshakes of the multislot packet buffer
interface packet_buffer_multislot_if #(
    parameter int DATA_W  = 64,
    parameter int ROUTE_W = 24
);
    logic [DATA_W-1:0]  in_data;
    logic [ROUTE_W-1:0] in_pkt_route;
    logic               in_wr;
    logic               in_empty;
    logic               in_req;
    logic               in_ack;
    logic [DATA_W-1:0]  out_data;
    logic [ROUTE_W-1:0] out_pkt_route;
    logic               out_wr;
    logic               out_req;
    logic               out_ack;
    logic [1:0]         out_neighbor;
    logic               out_bop;
    logic               out_eop;
    logic               out_rdy;
    logic               out_bypass;

    modport slave (
        input  in_data, in_pkt_route, in_wr, in_req, out_ack, out_rdy,
        output in_empty, in_ack, out_data, out_pkt_route, out_wr, out_req,
               out_neighbor, out_bop, out_eop, out_bypass
    );

    modport master (
        output in_data, in_pkt_route, in_wr, in_req, out_ack, out_rdy,
        input  in_empty, in_ack, out_data, out_pkt_route, out_wr, out_req,
               out_neighbor, out_bop, out_eop, out_bypass
    );
endinterface

// File: rtl/packet_buffer_multislot.sv
// packet_buffer_multislot: NUM_SLOTS-deep in-order packet store, receiving one packet while sending another
module packet_buffer_multislot #(
    parameter int DATA_W    = 64,
    parameter int ROUTE_W   = 24,
    parameter int NUM_SLOTS = 2,
    parameter int MAX_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    packet_buffer_multislot_if.slave   bus,
    output logic [$clog2(NUM_SLOTS):0] occupancy,
    output logic                       drop_pulse
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int AW = $clog2(MAX_WORDS);
    localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_WORDS);

    typedef enum logic {W_IDLE, W_RECV} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND, R_CANCEL} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [DATA_W-1:0]  mem [NUM_SLOTS*MAX_WORDS];
    logic [AW:0]        len_mem [NUM_SLOTS];
    logic [ROUTE_W-1:0] route_mem [NUM_SLOTS];
    logic [AW:0]        wr_len, rd_idx, rd_len;
    logic [SW-1:0]      wr_slot, rd_slot;
    logic ovf, free_slot, wr_en, commit, release_slot, issue;

    assign free_slot    = occupancy < (SW+1)'(NUM_SLOTS);
    assign wr_en        = w_state == W_RECV && bus.in_req && bus.in_wr && wr_len < MAX_LEN;
    assign commit       = w_state == W_RECV && !bus.in_req && wr_len != '0 && !ovf;
    assign release_slot = r_state == R_CANCEL && !bus.out_ack;
    assign rd_len       = len_mem[rd_slot];
    assign issue        = r_state == R_SEND && bus.out_rdy && rd_idx < rd_len;

    always_ff @(posedge clk or negedge reset)
        if (!reset) w_state <= W_IDLE;
        else w_state <= w_next;

    always_comb w_next = (bus.in_req && (w_state == W_RECV || free_slot)) ? W_RECV : W_IDLE;

    always_comb begin
        bus.in_ack   = w_state == W_RECV;
        bus.in_empty = w_state == W_IDLE && free_slot;
        drop_pulse   = w_state == W_RECV && !bus.in_req && (wr_len == '0 || ovf);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_len  <= '0;
            ovf     <= 1'b0;
            wr_slot <= '0;
        end else begin
            wr_len  <= w_state == W_IDLE ? '0 : wr_len + (AW+1)'(wr_en);
            ovf     <= w_state == W_RECV && (ovf || (bus.in_req && bus.in_wr && wr_len == MAX_LEN));
            wr_slot <= wr_slot + SW'(commit);
        end

    // the write slot is always free, so payload and metadata need no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_slot, wr_len[AW-1:0]}] <= bus.in_data;
        if (wr_en && wr_len == '0) route_mem[wr_slot] <= bus.in_pkt_route;
        if (commit) len_mem[wr_slot] <= wr_len;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= R_IDLE;
        else r_state <= r_next;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   if (occupancy != '0) r_next = R_REQ;
            R_REQ:    if (bus.out_ack) r_next = R_SEND;
            R_SEND:   if (bus.out_eop) r_next = R_CANCEL;
            R_CANCEL: if (!bus.out_ack) r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    always_comb bus.out_req = r_state == R_REQ || r_state == R_SEND;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_idx            <= '0;
            rd_slot           <= '0;
            occupancy         <= '0;
            bus.out_data      <= '0;
            bus.out_wr        <= 1'b0;
            bus.out_bop       <= 1'b0;
            bus.out_eop       <= 1'b0;
            bus.out_pkt_route <= '0;
            bus.out_neighbor  <= '0;
            bus.out_bypass    <= 1'b0;
        end else begin
            rd_idx      <= r_state == R_SEND ? rd_idx + (AW+1)'(issue) : '0;
            rd_slot     <= rd_slot + SW'(release_slot);
            occupancy   <= occupancy + (SW+1)'(commit) - (SW+1)'(release_slot);
            bus.out_wr  <= issue;
            bus.out_bop <= issue && rd_idx == '0;
            bus.out_eop <= issue && rd_idx == rd_len - (AW+1)'(1);
            if (issue) bus.out_data <= mem[{rd_slot, rd_idx[AW-1:0]}];
            if (r_state == R_IDLE && occupancy != '0) begin
                bus.out_pkt_route <= route_mem[rd_slot] >> 3;
                bus.out_neighbor  <= route_mem[rd_slot][1:0];
                bus.out_bypass    <= route_mem[rd_slot][5];
            end
        end
endmodule

// File: tb/tb_packet_buffer_multislot.sv
// tb_packet_buffer_multislot: directed scenarios with a word scoreboard for the multislot packet buffer
module tb_packet_buffer_multislot;
    localparam int DW = 64;
    localparam int RW = 24;
    localparam int NS = 2;
    localparam int MW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          bop;
        logic          eop;
        logic [RW-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [$clog2(NS):0] occupancy;
    logic drop_pulse;

    packet_buffer_multislot_if #(.DATA_W(DW), .ROUTE_W(RW)) bus ();

    packet_buffer_multislot #(.DATA_W(DW), .ROUTE_W(RW), .NUM_SLOTS(NS), .MAX_WORDS(MW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .occupancy(occupancy),
        .drop_pulse(drop_pulse)
    );

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic ack_en = 1'b0;
    logic rdy_toggle = 1'b0;
    logic burst = 1'b0;
    logic rdy_edge = 1'b0;
    logic prev_wr = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // downstream model: grant one cycle after out_req, release when out_req drops
    always @(negedge clk) begin
        cyc++;
        bus.out_ack = ack_en && bus.out_req;
        bus.out_rdy = !rdy_toggle || cyc[0];
    end

    always @(posedge clk) rdy_edge <= bus.out_rdy;

    always @(negedge clk) begin
        if (reset && bus.out_wr) begin
            chk("word_without_rdy", rdy_edge, 1'b1);
            if (burst && !bus.out_bop) chk("burst_gap", prev_wr, 1'b1);
            if (q.size() == 0) chk("extra_word", bus.out_wr, 1'b0);
            else begin
                e = q.pop_front();
                chk("data", bus.out_data, e.d);
                chk("bop", bus.out_bop, e.bop);
                chk("eop", bus.out_eop, e.eop);
                chk("route", bus.out_pkt_route, e.r >> 3);
                chk("neighbor", bus.out_neighbor, e.r[1:0]);
                chk("bypass", bus.out_bypass, e.r[5]);
            end
        end
        prev_wr = bus.out_wr;
    end

    task automatic grant(input int budget);
        bus.in_req = 1'b1;
        for (int c = 0; c < budget && !bus.in_ack; c++) @(negedge clk);
        chk("grant", bus.in_ack, 1'b1);
    endtask

    task automatic words(input logic [RW-1:0] r, input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            bus.in_wr = 1'b1;
            bus.in_data = d;
            bus.in_pkt_route = r;
            if (n <= MW) q.push_back({d, i == 0, i == n - 1, r});
            @(negedge clk);
        end
        bus.in_wr = 1'b0;
        bus.in_req = 1'b0;
        #1 chk("drop_pulse", drop_pulse, n == 0 || n > MW);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && (q.size() != 0 || occupancy != 0); c++) @(negedge clk);
        chk("drain_words", q.size(), 0);
        chk("drain_occ", occupancy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.in_req = 1'b0;
        bus.in_wr = 1'b0;
        bus.in_data = '0;
        bus.in_pkt_route = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_empty", bus.in_empty, 1'b1);
        chk("rst_in_ack", bus.in_ack, 1'b0);
        chk("rst_out_req", bus.out_req, 1'b0);
        chk("rst_out_wr", bus.out_wr, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_drop", drop_pulse, 1'b0);
        chk("rst_out_route", bus.out_pkt_route, 0);
        chk("rst_out_data", bus.out_data, 0);
        reset = 1'b1;
        @(negedge clk);

        ack_en = 1'b1;
        burst = 1'b1;
        grant(50);
        words(24'h000021, 4);
        chk("occ_single", occupancy, 1);
        drain();

        burst = 1'b0;
        rdy_toggle = 1'b1;
        grant(50);
        words(24'h000A03, 3);
        grant(50);
        chk("recv_during_send", bus.out_req, 1'b1);
        words(24'h00F1E6, 5);
        drain();
        rdy_toggle = 1'b0;

        ack_en = 1'b0;
        grant(50);
        words(24'h000111, 2);
        grant(50);
        words(24'h000222, 2);
        chk("occ_full", occupancy, 2);
        chk("in_empty_full", bus.in_empty, 1'b0);
        bus.in_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_grant_full", bus.in_ack, 1'b0);
        ack_en = 1'b1;
        grant(100);
        words(24'h000333, 3);
        drain();

        grant(50);
        words(24'h000044, MW + 1);
        chk("drop_once", drop_pulse, 1'b0);
        chk("occ_ovf", occupancy, 0);
        repeat (5) @(negedge clk);
        chk("no_req_ovf", bus.out_req, 1'b0);
        burst = 1'b1;
        grant(50);
        words(24'h000035, MW);
        drain();

        grant(50);
        words(24'h000001, 0);
        chk("occ_zero", occupancy, 0);
        chk("empty_zero", bus.in_empty, 1'b1);

        grant(50);
        words(24'h000027, 6);
        for (int c = 0; c < 50 && !bus.out_wr; c++) @(negedge clk);
        chk("send_started", bus.out_wr, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_out_req", bus.out_req, 1'b0);
        chk("rst_mid_out_wr", bus.out_wr, 1'b0);
        chk("rst_mid_occ", occupancy, 0);
        chk("rst_mid_in_empty", bus.in_empty, 1'b1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        grant(50);
        words(24'h000030, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/packet_buffer_multislot.md
Name: packet_buffer_multislot

Overview:
Parametrised successor to the single-slot bypass packet buffer. It holds up to NUM_SLOTS complete packets in one dual-port RAM. A new packet can be received while an earlier one is being sent, and packets leave in arrival order. Upstream and downstream handshakes are the same req/ack plus in_wr/out_rdy protocol as the existing buffer, so the block drops into the same router pipeline. It adds length overflow, zero-length discard and occupancy reporting.

Parameters:
DATA_W, 64, data word width
ROUTE_W, 24, route tag width (must be >= 6)
NUM_SLOTS, 2, packet slots (power of 2, >= 2)
MAX_WORDS, 256, max words per packet (power of 2); slot address width AW = log2(MAX_WORDS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
in_data  in  DATA_W  write data word
in_pkt_route  in  ROUTE_W  route tag, sampled with first in_wr of a packet
in_wr  in  1  word-valid strobe while receiving
in_empty  out  1  at least one free slot and write side idle
in_req  in  1  upstream request; held for the whole packet, dropped to end it
in_ack  out  1  grant; high for the whole receive
out_data  out  DATA_W  read data word
out_pkt_route  out  ROUTE_W  {3'b000, route[ROUTE_W-1:3]}
out_wr  out  1  out_data valid
out_req  out  1  request to downstream
out_ack  in  1  downstream grant
out_neighbor  out  2  route[1:0]
out_bop  out  1  with first word
out_eop  out  1  with last word
out_rdy  in  1  downstream can accept a word
out_bypass  out  1  route[5]
occupancy  out  log2(NUM_SLOTS)+1  number of committed, unsent-or-sending slots
drop_pulse  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset (async assert, sync release): both FSMs idle, all slots free, all counters 0.
- Reset values: all outputs 0 except in_empty=1.
- Reset mid-packet abandons the packet with no pulse; mid-send it drops out_req immediately.
- Storage: slot s, word i sits at RAM address {s, i}. Per slot, store len (AW+1 bits) and route. Commit and read queues use circular pointers mod NUM_SLOTS.
- Write FSM, W_IDLE:
  - in_empty = (occupancy < NUM_SLOTS).
  - If in_req and a free slot exists: go to W_RECV next cycle, clear wr_len and ovf.
- Write FSM, W_RECV:
  - in_ack=1, in_empty=0.
  - Each in_wr with wr_len < MAX_WORDS writes in_data at {wr_slot, wr_len} and increments wr_len.
  - The first in_wr also captures route.
  - An in_wr when wr_len == MAX_WORDS sets ovf; the data is not written.
  - On the cycle in_req==0: if wr_len==0 or ovf, drop_pulse=1 and the slot stays free; otherwise commit (len, route), advance wr_slot, occupancy+1. Then go to W_IDLE.
  - in_ack falls the cycle after in_req falls.
- Read FSM, R_IDLE: if a committed slot is at the read head, go to R_REQ.
  - Latch out_pkt_route, out_neighbor and out_bypass from that slot; they hold until the next packet.
- Read FSM, R_REQ: out_req=1; on out_ack go to R_SEND.
- Read FSM, R_SEND: out_req=1. RAM read latency is 1 cycle.
  - A cycle with out_rdy==1 and rd_idx < len issues a read of {rd_slot, rd_idx} and increments rd_idx.
  - The next cycle has out_wr=1 with that word; out_bop=(idx==0), out_eop=(idx==len-1).
  - out_wr/bop/eop are 0 on cycles with no issued read.
  - At most one word is in flight; a word issued before out_rdy fell is still delivered.
  - After the eop word go to R_CANCEL.
- Read FSM, R_CANCEL: out_req=0. When out_ack==0: free the slot, advance rd_slot, occupancy-1, go to R_IDLE.
- Same-cycle commit and free: occupancy unchanged.
- Read and write never touch the same slot, so there are no RAM port conflicts. Port A writes, port B reads.
- A packet of exactly MAX_WORDS words is accepted (len=MAX_WORDS, no ovf).
- A receive with all slots full is never granted; in_req simply waits.
- occupancy is a registered count.

Test Plan:
- Single packet: route 24'h00_0021, 4 words, out_rdy=1, out_ack returned 1 cycle after out_req -> out_wr for 4 consecutive cycles, bop on word0, eop on word3; out_neighbor=2'b01, out_bypass=1, out_pkt_route=24'h000004; occupancy 0->1->0.
- Overlap: packet A (3 words) sending with out_rdy toggling 1,0,1 while packet B (5 words) is received -> B accepted during A's send; outputs A then B with data intact; no out_wr when no read was issued.
- Full: NUM_SLOTS=2, downstream holds out_ack=0 -> after 2 packets in_empty=0 and a third in_req gets no in_ack until the first slot is freed.
- Overflow: MAX_WORDS=4, 5 in_wr -> drop_pulse once, occupancy unchanged, out_req never asserted. Then a 4-word packet -> sent intact with eop on word3.
- Zero length: in_req acked then dropped with no in_wr -> drop_pulse=1, slot stays free.
- Reset asserted mid-R_SEND -> out_req/out_wr/occupancy go to 0 asynchronously and in_empty=1; a fresh packet after release is sent correctly.
